// File: rtl/adex_param_sequencer.sv
// adex_param_sequencer
//
// Holds a 7-byte shadow copy of the AdEx neuron parameters and, on request,
// streams it into the neuron's nibble-serial loader:
//   SETUP (1 cycle) -> 16 x { STROBE_H (STROBE_HI cycles), STROBE_L (STROBE_LO cycles) }
//   -> EXIT (2 cycles, neuron commits) -> DONE (1 cycle) -> IDLE
// Strobe 0 carries 4'h0, strobes 1..14 carry the shadow bytes high nibble
// first, strobe 15 carries the 4'hF footer. The neuron core is frozen while
// the load is in progress.
//
// Optional feature: define ADEX_SEQ_STEP_LIMIT_EN to add a run step limiter
// (step_limit input, steps_done output). Without it, enable_core = run & ~busy.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   synchronous active-high reset
//   wr_en       in   shadow write strobe
//   wr_addr[3]  in   shadow index 0=DeltaT 1=TauW 2=a 3=b 4=Vreset 5=VT 6=Ibias
//   wr_data[8]  in   shadow write data
//   start       in   begin streaming the shadow set (accepted in IDLE only)
//   run         in   request to advance the neuron core
//   step_limit  in   (option) number of enabled cycles per run rise, 0=unlimited
//   steps_done  out  (option) pulse with the last permitted enabled cycle
//   load_mode   out  neuron loader mode pin
//   load_enable out  neuron loader nibble strobe
//   nibble[4]   out  nibble bus to neuron uio[3:0]
//   enable_core out  neuron core step enable
//   busy        out  load sequence in progress
//   done        out  one-cycle pulse at sequence completion
//   err         out  sticky illegal-write flag
module adex_param_sequencer #(
  parameter int STROBE_HI = 2,
  parameter int STROBE_LO = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        start,
  input  logic        run,
`ifdef ADEX_SEQ_STEP_LIMIT_EN
  input  logic [15:0] step_limit,
  output logic        steps_done,
`endif
  output logic        load_mode,
  output logic        load_enable,
  output logic [3:0]  nibble,
  output logic        enable_core,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_SETUP    = 3'd1;
  localparam logic [2:0] S_STROBE_H = 3'd2;
  localparam logic [2:0] S_STROBE_L = 3'd3;
  localparam logic [2:0] S_EXIT     = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [3:0] HI_LAST = 4'(STROBE_HI - 1);
  localparam logic [3:0] LO_LAST = 4'(STROBE_LO - 1);

  localparam logic [7:0] SHADOW_RST [0:6] = '{8'd2, 8'd100, 8'd2, 8'd40, 8'd191, 8'd206, 8'd128};

  logic [2:0] r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_strobe;
  logic [7:0] r_shadow [0:6];

  logic       r_load_mode;
  logic       r_load_enable;
  logic [3:0] r_nibble;
  logic       r_enable_core;
  logic       r_busy;
  logic       r_done;
  logic       r_err;

  logic [2:0] w_state_next;
  logic [3:0] w_cnt_next;
  logic [3:0] w_strobe_next;
  logic       w_busy;
  logic       w_busy_next;
  logic       w_wr_ok;
  logic       w_wr_bad;
  logic       w_start_ok;
  logic       w_en_next;
  logic [3:0] w_seq [0:15];

  // Sequencer next-state logic
  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_strobe_next = r_strobe;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_SETUP;
          w_cnt_next   = 4'd0;
        end
      end
      S_SETUP: begin
        w_state_next  = S_STROBE_H;
        w_cnt_next    = 4'd0;
        w_strobe_next = 4'd0;
      end
      S_STROBE_H: begin
        if (r_cnt == HI_LAST) begin
          w_state_next = S_STROBE_L;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_STROBE_L: begin
        if (r_cnt == LO_LAST) begin
          w_cnt_next = 4'd0;
          if (r_strobe == 4'd15) begin
            w_state_next = S_EXIT;
          end else begin
            w_state_next  = S_STROBE_H;
            w_strobe_next = r_strobe + 4'd1;
          end
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_EXIT: begin
        if (r_cnt == 4'd1) begin
          w_state_next = S_DONE;
          w_cnt_next   = 4'd0;
        end else begin
          w_cnt_next = r_cnt + 4'd1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  assign w_busy      = (r_state == S_SETUP) || (r_state == S_STROBE_H) ||
                       (r_state == S_STROBE_L) || (r_state == S_EXIT);
  assign w_busy_next = (w_state_next == S_SETUP) || (w_state_next == S_STROBE_H) ||
                       (w_state_next == S_STROBE_L) || (w_state_next == S_EXIT);
  assign w_wr_ok     = wr_en && !w_busy && (wr_addr != 3'd7);
  assign w_wr_bad    = wr_en && (w_busy || (wr_addr == 3'd7));
  assign w_start_ok  = (r_state == S_IDLE) && start;

  // Shadow registers: writes only outside the load so a stream is never torn
  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_shadow
      always_ff @(posedge clk) begin
        if (reset) begin
          r_shadow[gi] <= SHADOW_RST[gi];
        end else if (w_wr_ok && (wr_addr == 3'(gi))) begin
          r_shadow[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Nibble carried by each of the 16 strobes
  generate
    for (gi = 0; gi < 16; gi++) begin : g_seq
      if (gi == 0) begin : g_head
        assign w_seq[gi] = 4'h0;
      end else if (gi == 15) begin : g_foot
        assign w_seq[gi] = 4'hF;
      end else if ((gi % 2) == 1) begin : g_high
        assign w_seq[gi] = r_shadow[(gi - 1) / 2][7:4];
      end else begin : g_low
        assign w_seq[gi] = r_shadow[(gi - 1) / 2][3:0];
      end
    end
  endgenerate

`ifdef ADEX_SEQ_STEP_LIMIT_EN
  logic        r_run_d;
  logic        r_limited;
  logic [15:0] r_steps_left;
  logic        r_steps_done;
  logic        w_run_rise;
  logic        w_limited;
  logic [15:0] w_remaining;

  // A run rising edge reloads the budget; a zero limit means unlimited.
  assign w_run_rise  = run && !r_run_d;
  assign w_limited   = w_run_rise ? (step_limit != 16'd0) : r_limited;
  assign w_remaining = w_run_rise ? step_limit : r_steps_left;
  assign w_en_next   = run && !w_busy_next && (!w_limited || (w_remaining != 16'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_run_d      <= 1'b0;
      r_limited    <= 1'b0;
      r_steps_left <= 16'd0;
      r_steps_done <= 1'b0;
    end else begin
      r_run_d      <= run;
      r_limited    <= w_limited;
      r_steps_left <= (w_limited && w_en_next) ? (w_remaining - 16'd1) : w_remaining;
      r_steps_done <= w_limited && w_en_next && (w_remaining == 16'd1);
    end
  end

  assign steps_done = r_steps_done;
`else
  assign w_en_next = run && !w_busy_next;
`endif

  // State and registered outputs; outputs are decoded from the next state so
  // they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_strobe      <= 4'd0;
      r_load_mode   <= 1'b0;
      r_load_enable <= 1'b0;
      r_nibble      <= 4'h0;
      r_enable_core <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_cnt         <= w_cnt_next;
      r_strobe      <= w_strobe_next;
      r_load_mode   <= w_busy_next;
      r_busy        <= w_busy_next;
      r_load_enable <= (w_state_next == S_STROBE_H);
      r_done        <= (w_state_next == S_DONE);
      r_enable_core <= w_en_next;
      if (w_state_next == S_SETUP) begin
        r_nibble <= 4'h0;
      end else if ((w_state_next == S_STROBE_H) && (r_state != S_STROBE_H)) begin
        r_nibble <= w_seq[w_strobe_next];
      end
      // An illegal write in the same cycle as an accepted start still flags.
      if (w_wr_bad) begin
        r_err <= 1'b1;
      end else if (w_start_ok) begin
        r_err <= 1'b0;
      end
    end
  end

  assign load_mode   = r_load_mode;
  assign load_enable = r_load_enable;
  assign nibble      = r_nibble;
  assign enable_core = r_enable_core;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_adex_param_sequencer.sv
// Self-checking bench for adex_param_sequencer: per-cycle reference model,
// a table of shadow-write vectors, hand-written corner sequences and a
// randomized run.
module tb_adex_param_sequencer;

  localparam int HI       = 2;
  localparam int LO       = 2;
  localparam int P        = HI + LO;
  localparam int BUSY_LEN = 3 + 16 * P;
  localparam int DONE_P   = BUSY_LEN + 1;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, run;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       load_mode, load_enable, enable_core, busy, done, err;
  logic [3:0] nibble;
`ifdef ADEX_SEQ_STEP_LIMIT_EN
  logic [15:0] step_limit;
  logic        steps_done;
`endif

  always #5 clk = ~clk;

  adex_param_sequencer #(.STROBE_HI(HI), .STROBE_LO(LO)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .run(run),
`ifdef ADEX_SEQ_STEP_LIMIT_EN
    .step_limit(step_limit), .steps_done(steps_done),
`endif
    .load_mode(load_mode), .load_enable(load_enable), .nibble(nibble),
    .enable_core(enable_core), .busy(busy), .done(done), .err(err)
  );

  // Reference model: m_p = cycles since an accepted start (0 = idle)
  int         m_p;
  logic [7:0] m_sh [8];
  logic [3:0] m_seq [16];
  logic [3:0] m_nib;
  logic       m_err, m_en;
`ifdef ADEX_SEQ_STEP_LIMIT_EN
  logic       m_run_d, m_lim, m_sdone;
  int         m_left;
`endif

  int checks = 0;
  int errors = 0;
  logic [3:0] cap [16];
  int   cap_n = 0;
  logic prev_le = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_err = 1'b0; m_nib = 4'h0; m_en = 1'b0;
    m_sh[0] = 8'd2;   m_sh[1] = 8'd100; m_sh[2] = 8'd2;   m_sh[3] = 8'd40;
    m_sh[4] = 8'd191; m_sh[5] = 8'd206; m_sh[6] = 8'd128; m_sh[7] = 8'd0;
`ifdef ADEX_SEQ_STEP_LIMIT_EN
    m_run_d = 1'b0; m_lim = 1'b0; m_left = 0; m_sdone = 1'b0;
`endif
  endtask

  function automatic logic m_busy_of(input int p);
    return (p >= 1) && (p <= BUSY_LEN);
  endfunction

  // Advance the model by one clock edge using the inputs present at it
  task automatic model_edge();
    logic busy_now, bad, accept;
    if (reset) begin
      model_reset();
    end else begin
      busy_now = m_busy_of(m_p);
      bad = 1'b0; accept = 1'b0;
      if (wr_en) begin
        if (busy_now || wr_addr == 3'd7) bad = 1'b1;
        else m_sh[wr_addr] = wr_data;
      end
      if (m_p == 0 && start) begin
        accept = 1'b1;
        m_p = 1;
        m_seq[0] = 4'h0; m_seq[15] = 4'hF;
        for (int b = 0; b < 7; b++) begin
          m_seq[1 + 2 * b] = m_sh[b][7:4];
          m_seq[2 + 2 * b] = m_sh[b][3:0];
        end
      end else if (m_p > 0) begin
        m_p = (m_p == DONE_P) ? 0 : m_p + 1;
      end
      if (accept) m_err = 1'b0;
      if (bad) m_err = 1'b1;
      if (m_p == 1) m_nib = 4'h0;
      else if (m_p >= 2 && m_p <= 1 + 16 * P && ((m_p - 2) % P) == 0) m_nib = m_seq[(m_p - 2) / P];
`ifdef ADEX_SEQ_STEP_LIMIT_EN
      if (run && !m_run_d) begin
        m_lim = (step_limit != 16'd0);
        m_left = int'(step_limit);
      end
      m_run_d = run;
      m_en = run && !m_busy_of(m_p) && (!m_lim || m_left > 0);
      m_sdone = 1'b0;
      if (m_en && m_lim) begin
        m_left--;
        m_sdone = (m_left == 0);
      end
`else
      m_en = run && !m_busy_of(m_p);
`endif
    end
  endtask

  function automatic logic [9:0] exp_outs();
    logic b, le, dn;
    b  = m_busy_of(m_p);
    le = (m_p >= 2) && (m_p <= 1 + 16 * P) && (((m_p - 2) % P) < HI);
    dn = (m_p == DONE_P);
    return {b, le, m_nib, m_en, b, dn, m_err};
  endfunction

  function automatic logic [9:0] dut_outs();
    return {load_mode, load_enable, nibble, enable_core, busy, done, err};
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle_outputs", 32'(dut_outs()), 32'(exp_outs()));
`ifdef ADEX_SEQ_STEP_LIMIT_EN
    check("steps_done", 32'(steps_done), 32'(m_sdone));
`endif
    if (load_enable && !prev_le) begin
      if (cap_n < 16) cap[cap_n] = nibble;
      cap_n++;
    end
    prev_le = load_enable;
  endtask

  task automatic run_to_done(output int n);
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    if (!done) check("done_timeout", 32'(n), 32'(BUSY_LEN));
  endtask

  task automatic start_seq(output int n);
    start = 1'b1; cap_n = 0;
    step();
    start = 1'b0; wr_en = 1'b0;
    run_to_done(n);
    step();  // DONE -> IDLE
  endtask

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
    int         idx;
    logic [3:0] hi;
    logic [3:0] lo;
    logic       err;
  } vec_t;

  vec_t tbl [6];
  logic [3:0] exp_seq [16] = '{4'h0, 4'h0, 4'h2, 4'h6, 4'h4, 4'h0, 4'h2, 4'h2,
                               4'h8, 4'hB, 4'hF, 4'hC, 4'hE, 4'h8, 4'h0, 4'hF};

  initial begin
    int n, bad_en;
    tbl[0] = '{3'd5, 8'hD2, 11, 4'hD, 4'h2, 1'b0};
    tbl[1] = '{3'd0, 8'h3C, 1,  4'h3, 4'hC, 1'b0};
    tbl[2] = '{3'd6, 8'hA5, 13, 4'hA, 4'h5, 1'b0};
    tbl[3] = '{3'd7, 8'h55, 1,  4'h3, 4'hC, 1'b1};
    tbl[4] = '{3'd1, 8'hFF, 3,  4'hF, 4'hF, 1'b0};
    tbl[5] = '{3'd3, 8'h01, 7,  4'h0, 4'h1, 1'b0};

    reset = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'd0; start = 1'b0; run = 1'b0;
`ifdef ADEX_SEQ_STEP_LIMIT_EN
    step_limit = 16'd0;
`endif
    model_reset();
    repeat (3) step();
    check("reset_state", 32'(dut_outs()), 32'd0);
    reset = 1'b0;
    step();

    // Default shadow set stream and done latency
    start_seq(n);
    check("done_latency", 32'(n), 32'(BUSY_LEN));
    check("strobe_count", 32'(cap_n), 32'd16);
    for (int i = 0; i < 16; i++) check($sformatf("default_nib[%0d]", i), 32'(cap[i]), 32'(exp_seq[i]));
    $display("default sequence: latency %0d, %0d strobes", n, cap_n);

    // Table of shadow writes, each followed by a full stream
    for (int t = 0; t < 6; t++) begin
      wr_en = 1'b1; wr_addr = tbl[t].addr; wr_data = tbl[t].data;
      step();
      wr_en = 1'b0;
      check($sformatf("tbl%0d_err", t), 32'(err), 32'(tbl[t].err));
      start_seq(n);
      check($sformatf("tbl%0d_hi", t), 32'(cap[tbl[t].idx]), 32'(tbl[t].hi));
      check($sformatf("tbl%0d_lo", t), 32'(cap[tbl[t].idx + 1]), 32'(tbl[t].lo));
      check($sformatf("tbl%0d_err_clr", t), 32'(err), 32'd0);
      $display("vector %0d: addr %0d data %h -> %h%h", t, tbl[t].addr, tbl[t].data,
               cap[tbl[t].idx], cap[tbl[t].idx + 1]);
    end

    // Write and start in the same IDLE cycle: new value is streamed
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h9E;
    start_seq(n);
    check("same_cycle_hi", 32'(cap[5]), 32'h9);
    check("same_cycle_lo", 32'(cap[6]), 32'hE);
    $display("write+start: a streamed as %h%h", cap[5], cap[6]);

    // Write while busy is discarded and flags err; a start mid-load is ignored
    start = 1'b1; cap_n = 0;
    step();
    start = 1'b0;
    repeat (9) step();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h77;
    step();
    wr_en = 1'b0;
    check("busy_write_err", 32'(err), 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("busy_start_err_kept", 32'(err), 32'd1);
    run_to_done(n);
    check("busy_start_latency", 32'(n + 11), 32'(BUSY_LEN));
    step();
    check("b_unchanged_hi", 32'(cap[7]), 32'h0);
    check("b_unchanged_lo", 32'(cap[8]), 32'h1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("err_clear_on_start", 32'(err), 32'd0);
    run_to_done(n);
    step();
    $display("busy write: err flagged, b kept %h%h", cap[7], cap[8]);

    // Reset mid-sequence: no footer afterwards
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (29) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midreset_load_mode", 32'(load_mode), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    cap_n = 0;
    repeat (80) step();
    check("midreset_no_footer", 32'(cap_n), 32'd0);
    $display("mid-sequence reset: %0d strobes afterwards", cap_n);

    // run held through a load: core frozen while busy
    run = 1'b1;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    bad_en = 0;
    n = 0;
    while (!done && n < 200) begin
      if (busy && enable_core) bad_en++;
      step();
      n++;
    end
    check("frozen_core", 32'(bad_en), 32'd0);
    step();
    check("core_after_done", 32'(enable_core), 32'd1);
    run = 1'b0;
    step();
    $display("run held: %0d enabled busy cycles", bad_en);

`ifdef ADEX_SEQ_STEP_LIMIT_EN
    begin
      int en_cnt, sd_cnt;
      en_cnt = 0; sd_cnt = 0;
      step_limit = 16'd5;
      step();
      run = 1'b1;
      for (int i = 0; i < 30; i++) begin
        step();
        if (enable_core) en_cnt++;
        if (steps_done) sd_cnt++;
      end
      run = 1'b0;
      step_limit = 16'd0;
      step();
      check("limit_enables", 32'(en_cnt), 32'd5);
      check("limit_pulses", 32'(sd_cnt), 32'd1);
      $display("step limit 5: %0d enables, %0d steps_done", en_cnt, sd_cnt);
    end
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      wr_en   = ($urandom_range(0, 7) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 8'($urandom);
      start   = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 9) == 0) run = ~run;
      reset   = ($urandom_range(0, 599) == 0);
`ifdef ADEX_SEQ_STEP_LIMIT_EN
      if ($urandom_range(0, 49) == 0) step_limit = 16'($urandom_range(0, 8));
`endif
      step();
    end
    reset = 1'b0; wr_en = 1'b0; start = 1'b0; run = 1'b0;
    step();
    $display("random phase: 4000 cycles");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adex_param_sequencer.md
ADEX_PARAM_SEQUENCER -- requirements
Module: adex_param_sequencer

Interface
REQ-001 SHALL have parameter STROBE_HI, default 2, cycles load_enable is held high per strobe (legal range 1..15).
REQ-002 SHALL have parameter STROBE_LO, default 2, cycles load_enable is held low after each strobe (legal range 2..15).
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port wr_en  input  1  parameter shadow-register write strobe.
REQ-006 SHALL have port wr_addr  input  3  shadow index: 0=DeltaT, 1=TauW, 2=a, 3=b, 4=Vreset, 5=VT, 6=Ibias.
REQ-007 SHALL have port wr_data  input  8  shadow write data.
REQ-008 SHALL have port start  input  1  request to stream the shadow set into the neuron loader.
REQ-009 SHALL have port run  input  1  request to advance the neuron core.
REQ-010 SHALL have port load_mode  output  1  neuron loader mode pin.
REQ-011 SHALL have port load_enable  output  1  neuron loader nibble strobe.
REQ-012 SHALL have port nibble  output  4  nibble bus to the neuron uio[3:0].
REQ-013 SHALL have port enable_core  output  1  neuron core step enable.
REQ-014 SHALL have port busy  output  1  load sequence in progress.
REQ-015 SHALL have port done  output  1  one-cycle pulse at sequence completion.
REQ-016 SHALL have port err  output  1  sticky illegal-write flag.

Function
REQ-017 All outputs SHALL be registered.
REQ-018 FSM states SHALL be IDLE, SETUP, STROBE_H, STROBE_L, EXIT, DONE.
REQ-019 In IDLE, start=1 SHALL move to SETUP; start while not IDLE SHALL be ignored without error.
REQ-020 SETUP SHALL last 1 cycle: load_mode=1, load_enable=0, nibble=0.
REQ-021 Then 16 strobes SHALL follow, each STROBE_HI cycles in STROBE_H (load_enable=1) then STROBE_LO cycles in STROBE_L (load_enable=0); load_mode=1 throughout.
REQ-022 Strobe 0 SHALL carry nibble 4'h0 (start); strobes 1..14 SHALL carry shadow[0..6], high nibble then low nibble per byte; strobe 15 SHALL carry footer 4'hF.
REQ-023 nibble SHALL change only on the first STROBE_H cycle of each strobe and hold through the following STROBE_L.
REQ-024 EXIT SHALL last 2 cycles with load_mode=1, load_enable=0, so the neuron commits its parameters; DONE SHALL last 1 cycle with load_mode=0, done=1, then return to IDLE.
REQ-025 busy SHALL be 1 in SETUP, STROBE_H, STROBE_L and EXIT only; total busy = 3+16*(STROBE_HI+STROBE_LO) cycles (67 at defaults).
REQ-026 wr_en in IDLE or DONE with wr_addr<=6 SHALL update the shadow on the next edge; write and start in the same IDLE cycle SHALL both take effect, and the new value SHALL be streamed.
REQ-027 wr_en while busy, or with wr_addr=7, SHALL be discarded and SHALL set err; err SHALL clear only on reset or an accepted start.
REQ-028 enable_core SHALL equal run AND NOT busy (registered); the core is frozen for the whole load.

Reset
REQ-029 Reset SHALL force IDLE with load_mode=0, load_enable=0, nibble=0, enable_core=0, busy=0, done=0, err=0, mid-sequence included, with no footer emitted.
REQ-030 Shadow reset values SHALL be DeltaT=2, TauW=100, a=2, b=40, Vreset=191, VT=206, Ibias=128.

Configuration
REQ-031 Macro ADEX_SEQ_STEP_LIMIT_EN defined SHALL add input step_limit[15:0] and output steps_done[1]; a rising edge of run SHALL load a 16-bit down-counter from step_limit, enable_core SHALL deassert once step_limit enabled cycles are issued, and steps_done SHALL pulse one cycle then; step_limit=0 SHALL mean unlimited.
REQ-032 Macro undefined SHALL leave those ports and counter absent and enable_core per REQ-028.

Verification
REQ-033 Reset, start with defaults -> nibble sequence 0,0,2,6,4,0,2,2,8,B,F,C,E,8,0,F on 16 load_enable rising edges; done pulses 67 cycles after busy rises.
REQ-034 Write addr 5=0xD2 then start -> strobes 11/12 carry D/2; neuron loader reaches commit (VT updated).
REQ-035 wr_en addr 3 at busy cycle 10 -> shadow b unchanged, err=1; next accepted start -> err=0.
REQ-036 Reset asserted at busy cycle 30 -> next cycle load_mode=0, busy=0, no footer nibble observed.
REQ-037 run=1 held during start -> enable_core=0 for all busy cycles, 1 again in the cycle after done.
REQ-038 With ADEX_SEQ_STEP_LIMIT_EN, step_limit=5, run rises -> exactly 5 enable_core cycles, steps_done pulses once.
